lab7_sos_nios2_qsys_0_oci_dct_ctrl: RTL and testbench

Sequencer for the OCI data-compressed-trace (DCT) packing buffer. It accepts 2-bit trace atoms from the OCI trace source and packs them into a 30-bit buffer (up to 15 atoms), exposing the live buffer and count. It emits completed or partial buffers as 36-bit trace words to the trace RAM writer over a valid/ready handshake. It also sequences the end-of-test drain that drives test_ending and test_has_ended on the OCI test bench.

---
 rtl/lab7_sos_nios2_qsys_0_oci_dct_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_lab7_sos_nios2_qsys_0_oci_dct_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab7_sos_nios2_qsys_0_oci_dct_ctrl.sv
// ---------------------------------------------------------------------------
// lab7_sos_nios2_qsys_0_oci_dct_ctrl
//
// Sequencer for the OCI data-compressed-trace (DCT) packing buffer.
//
// Trace atoms of 2 bits are packed into a 30-bit buffer of up to 15 slots.
// Slot k occupies dct_buffer[2k+1:2k]. A full buffer, or a partial buffer
// during the end-of-test drain, is emitted as a 36-bit trace word
// {2'b10, count[3:0], buffer[29:0]} over a valid/ready handshake.
//
// The drain starts on trace_stop. It flushes whatever is left in the buffer,
// waits for the output slot to empty, and then parks in ENDED until reset.
//
// Optional build macro: LAB7_SOS_OCI_DCT_TIMEOUT_EN
//   When defined, an idle timer flushes a partial buffer once TIMEOUT cycles
//   have passed since the last accepted atom. When undefined, there is no
//   timer, and partial words leave only through the drain.
//
// Parameters:
//   TIMEOUT        idle cycles before a partial flush (2..65535, timer build only)
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        synchronous active-low reset
//   atom_valid     trace atom present
//   atom_data[1:0] trace atom value
//   atom_ready     atom accepted when atom_valid && atom_ready
//   trace_stop     single-cycle end-of-trace request
//   tw_valid       trace word valid
//   tw_data[35:0]  trace word
//   tw_ready       trace RAM writer accepts the word
//   dct_buffer     live packing buffer
//   dct_count      atoms currently held in dct_buffer (0..15)
//   test_ending    high while a drain is in progress
//   test_has_ended sticky, set when the drain completes
// ---------------------------------------------------------------------------
module lab7_sos_nios2_qsys_0_oci_dct_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        atom_valid,
  input  logic [1:0]  atom_data,
  output logic        atom_ready,
  input  logic        trace_stop,
  output logic        tw_valid,
  output logic [35:0] tw_data,
  input  logic        tw_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_ending,
  output logic        test_has_ended
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    ENDED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [29:0] buffer_next;
  logic [3:0]  count_next;
  logic        tw_valid_next;
  logic [35:0] tw_data_next;
  logic        out_free;
  logic        accept;
  logic        load_word;
  logic        flush_due;
  logic [4:0]  slot_lsb;

  // The output register can take a new word when it is empty, or when its
  // current word is being handed off in this same cycle.
  assign out_free = !tw_valid || tw_ready;

  // A full buffer can still take an atom if the word moves out this cycle,
  // because that atom then lands in slot 0 of the freshly cleared buffer.
  assign atom_ready = (state == FILL) && ((dct_count != 4'd15) || out_free);
  assign accept     = atom_valid && atom_ready;

  assign slot_lsb = {dct_count, 1'b0};

  assign test_ending    = (state == DRAIN);
  assign test_has_ended = (state == ENDED);

`ifdef LAB7_SOS_OCI_DCT_TIMEOUT_EN
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  logic [15:0] timer;
  logic [15:0] timer_next;

  // The flush fires only for a partial buffer. A full buffer always leaves
  // through the normal full-transfer path.
  assign flush_due = (timer == TIMER_LAST) && (dct_count != 4'd0) &&
                     (dct_count != 4'd15);

  // The idle timer restarts on any activity and whenever nothing is waiting.
  // When it reaches its last value it holds there until the flush can go out.
  always_comb begin
    timer_next = timer;
    if ((state != FILL) || load_word || accept || (dct_count == 4'd0)) begin
      timer_next = 16'd0;
    end else if (timer != TIMER_LAST) begin
      timer_next = timer + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer <= 16'd0;
    end else begin
      timer <= timer_next;
    end
  end
`else
  logic [15:0] unused_timeout;

  assign unused_timeout = 16'(TIMEOUT);
  assign flush_due      = 1'b0;
`endif

  // Next-state and datapath logic. A word is loaded when a full buffer can
  // move out, when an idle partial buffer times out, or while draining. An
  // atom accepted in the same cycle as a load goes to slot 0 of the cleared
  // buffer. Otherwise the atom is appended at the current count.
  always_comb begin
    state_next    = state;
    buffer_next   = dct_buffer;
    count_next    = dct_count;
    tw_valid_next = tw_valid;
    tw_data_next  = tw_data;
    load_word     = 1'b0;

    case (state)
      FILL: begin
        if (((dct_count == 4'd15) || flush_due) && out_free) begin
          load_word = 1'b1;
        end
        if (trace_stop) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_free) begin
          if (dct_count != 4'd0) begin
            load_word = 1'b1;
          end else begin
            state_next = ENDED;
          end
        end
      end
      default: begin
      end
    endcase

    if (load_word) begin
      tw_valid_next = 1'b1;
      tw_data_next  = {2'b10, dct_count, dct_buffer};
      buffer_next   = 30'd0;
      count_next    = 4'd0;
    end else if (tw_valid && tw_ready) begin
      tw_valid_next = 1'b0;
    end

    if (accept) begin
      if (load_word) begin
        buffer_next = {28'd0, atom_data};
        count_next  = 4'd1;
      end else begin
        buffer_next[slot_lsb +: 2] = atom_data;
        count_next                 = dct_count + 4'd1;
      end
    end
  end

  // State, buffer and output word registers. Reset drops any pending word
  // and any partial buffer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= FILL;
      dct_buffer <= 30'd0;
      dct_count  <= 4'd0;
      tw_valid   <= 1'b0;
      tw_data    <= 36'd0;
    end else begin
      state      <= state_next;
      dct_buffer <= buffer_next;
      dct_count  <= count_next;
      tw_valid   <= tw_valid_next;
      tw_data    <= tw_data_next;
    end
  end

endmodule

// File: tb/tb_lab7_sos_nios2_qsys_0_oci_dct_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lab7_sos_nios2_qsys_0_oci_dct_ctrl
//
// Directed testbench for the DCT packing sequencer.
//
// A queue-based reference model runs alongside the design, and a single
// process compares every output against it on each falling edge. Directed
// scenarios also pin the model with hand-computed literal values.
//
// Inputs change 1 time unit after each rising edge, so they are stable at
// both the falling edge and the next rising edge.
// ---------------------------------------------------------------------------
module tb_lab7_sos_nios2_qsys_0_oci_dct_ctrl;

  localparam int TO = 4;
`ifdef LAB7_SOS_OCI_DCT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom_data = 2'd0;
  logic        trace_stop = 1'b0;
  logic        tw_ready = 1'b0;
  logic        atom_ready;
  logic        tw_valid;
  logic [35:0] tw_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;

  int n_vectors = 0;
  int n_miscompares = 0;

  lab7_sos_nios2_qsys_0_oci_dct_ctrl #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .trace_stop     (trace_stop),
    .tw_valid       (tw_valid),
    .tw_data        (tw_data),
    .tw_ready       (tw_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  // Reference model state: the atoms held in the buffer, a phase
  // (0 fill, 1 drain, 2 ended), the output register, and the idle timer.
  logic [1:0]  m_atoms[$];
  int          m_phase = 0;
  bit          m_out_valid = 1'b0;
  logic [35:0] m_out_word = 36'd0;
  int          m_timer = 0;
  bit          m_live = 1'b0;

  function automatic logic [29:0] packAtoms();
    logic [29:0] r;
    r = 30'd0;
    foreach (m_atoms[i]) r[2*i +: 2] = m_atoms[i];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [35:0] actual,
                             input logic [35:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Advance the model by one rising edge, using the inputs that will be
  // sampled at that edge.
  task automatic modelStep();
    bit free;
    bit acc;
    bit loaded;
    int old_size;
    int old_phase;
    if (!reset_n) begin
      m_atoms.delete();
      m_phase     = 0;
      m_out_valid = 1'b0;
      m_out_word  = 36'd0;
      m_timer     = 0;
      m_live      = 1'b1;
    end else if (m_live) begin
      free      = !m_out_valid || tw_ready;
      acc       = atom_valid && (m_phase == 0) && (m_atoms.size() != 15 || free);
      loaded    = 1'b0;
      old_size  = m_atoms.size();
      old_phase = m_phase;
      if (m_phase == 0) begin
        if (old_size == 15 && free) loaded = 1'b1;
        else if (TO_EN && m_timer == TO - 1 && old_size > 0 && free) loaded = 1'b1;
        if (trace_stop) m_phase = 1;
      end else if (m_phase == 1) begin
        if (old_size > 0 && free) loaded = 1'b1;
        else if (free) m_phase = 2;
      end
      if (loaded) begin
        m_out_word  = {2'b10, 4'(old_size), packAtoms()};
        m_out_valid = 1'b1;
        m_atoms.delete();
      end else if (m_out_valid && tw_ready) begin
        m_out_valid = 1'b0;
      end
      if (acc) m_atoms.push_back(atom_data);
      if (old_phase != 0 || loaded || acc || old_size == 0) m_timer = 0;
      else if (m_timer < TO - 1) m_timer = m_timer + 1;
    end
  endtask

  // Compare process: on every falling edge, check the DUT against the
  // model, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        checkOutput("atom_ready", 36'(atom_ready),
                    36'((m_phase == 0) && (m_atoms.size() != 15 || !m_out_valid || tw_ready)));
        checkOutput("dct_buffer", 36'(dct_buffer), 36'(packAtoms()));
        checkOutput("dct_count", 36'(dct_count), 36'(m_atoms.size()));
        checkOutput("tw_valid", 36'(tw_valid), 36'(m_out_valid));
        checkOutput("tw_data", tw_data, m_out_word);
        checkOutput("test_ending", 36'(test_ending), 36'(m_phase == 1));
        checkOutput("test_has_ended", 36'(test_has_ended), 36'(m_phase == 2));
      end
      modelStep();
    end
  end

  task automatic applyStimulus(input bit v, input logic [1:0] d, input bit stop,
                               input bit rdy);
    atom_valid = v;
    atom_data  = d;
    trace_stop = stop;
    tw_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  // Hold an atom until the design takes it, within a bounded number of cycles.
  task automatic sendAtom(input logic [1:0] d, input bit rdy);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      atom_valid = 1'b1;
      atom_data  = d;
      trace_stop = 1'b0;
      tw_ready   = rdy;
      @(negedge clk);
      got = atom_ready;
      @(posedge clk);
      #1;
    end
    atom_valid = 1'b0;
    if (!got) begin
      n_vectors++;
      n_miscompares++;
      $display("[TB] FAIL send_timeout: atom %0d not accepted, expected acceptance", d);
    end
  endtask

  task automatic resetDut(input bit rdy);
    reset_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, rdy);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    reset_n = 1'b1;
    checkOutput("rst_tw_valid", 36'(tw_valid), 36'd0);
    checkOutput("rst_tw_data", tw_data, 36'd0);
    checkOutput("rst_count", 36'(dct_count), 36'd0);
    checkOutput("rst_ended", 36'(test_has_ended), 36'd0);

    // Fifteen atoms of 01 fill the buffer; the word appears one edge later
    $display("[TB] scenario: full buffer transfer");
    for (int i = 0; i < 15; i++) sendAtom(2'b01, 1'b1);
    checkOutput("t1_count15", 36'(dct_count), 36'd15);
    checkOutput("t1_no_word_yet", 36'(tw_valid), 36'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("t1_tw_valid", 36'(tw_valid), 36'd1);
    checkOutput("t1_tw_data", tw_data, {2'b10, 4'd15, 30'h1555_5555});
    checkOutput("t1_count0", 36'(dct_count), 36'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("t1_tw_valid_drop", 36'(tw_valid), 36'd0);

    // Back-pressure: 30 atoms with no ready, then a stalled 31st atom
    $display("[TB] scenario: back-pressure");
    resetDut(1'b0);
    for (int i = 1; i <= 30; i++) sendAtom(2'(i % 4), 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
      checkOutput("t2_stall_ready", 36'(atom_ready), 36'd0);
      checkOutput("t2_stall_count", 36'(dct_count), 36'd15);
      checkOutput("t2_held_word", tw_data, {2'b10, 4'd15, 30'h3939_3939});
    end
    checkOutput("t2_buffer2", 36'(dct_buffer), 36'(30'h24E4_E4E4));
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b1);
    checkOutput("t2_tw_valid", 36'(tw_valid), 36'd1);
    checkOutput("t2_word2", tw_data, {2'b10, 4'd15, 30'h24E4_E4E4});
    checkOutput("t2_slot0_count", 36'(dct_count), 36'd1);
    checkOutput("t2_slot0_buf", 36'(dct_buffer), 36'd3);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("t2_drop", 36'(tw_valid), 36'd0);

    // Drain with a partial buffer holding atoms 1,2,3 in slots 0..2
    $display("[TB] scenario: drain partial buffer");
    resetDut(1'b1);
    sendAtom(2'd1, 1'b1);
    sendAtom(2'd2, 1'b1);
    sendAtom(2'd3, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
    checkOutput("t3_ending", 36'(test_ending), 36'd1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("t3_tw_valid", 36'(tw_valid), 36'd1);
    checkOutput("t3_tw_data", tw_data, {2'b10, 4'd3, 30'h0000_0039});
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("t3_has_ended", 36'(test_has_ended), 36'd1);
    checkOutput("t3_ending_low", 36'(test_ending), 36'd0);
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("t3_sticky", 36'(test_has_ended), 36'd1);

    // Drain with an empty buffer
    $display("[TB] scenario: empty drain");
    resetDut(1'b1);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
    checkOutput("t4_ending", 36'(test_ending), 36'd1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("t4_has_ended", 36'(test_has_ended), 36'd1);
    checkOutput("t4_no_word", 36'(tw_valid), 36'd0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
    checkOutput("t4_ready_low", 36'(atom_ready), 36'd0);

    // Reset in the middle of operation
    $display("[TB] scenario: mid-operation reset");
    resetDut(1'b0);
    for (int i = 0; i < 15; i++) sendAtom(2'd2, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) sendAtom(2'd1, 1'b0);
    checkOutput("t5_pre_valid", 36'(tw_valid), 36'd1);
    checkOutput("t5_pre_count", 36'(dct_count), 36'd7);
    resetDut(1'b0);
    checkOutput("t5_valid", 36'(tw_valid), 36'd0);
    checkOutput("t5_data", tw_data, 36'd0);
    checkOutput("t5_count", 36'(dct_count), 36'd0);
    checkOutput("t5_buffer", 36'(dct_buffer), 36'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      checkOutput("t5_no_replay", 36'(tw_valid), 36'd0);
    end

    // Idle partial buffer: flushed after TO cycles only in the timer build
    $display("[TB] scenario: idle partial buffer");
    resetDut(1'b1);
    sendAtom(2'd2, 1'b1);
    sendAtom(2'd1, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      checkOutput("t6_flush_timing", 36'(tw_valid), 36'(TO_EN && k == TO));
      if (TO_EN && k == TO)
        checkOutput("t6_flush_word", tw_data, {2'b10, 4'd2, 30'h0000_0006});
    end
    checkOutput("t6_count_after", 36'(dct_count), TO_EN ? 36'd0 : 36'd2);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("t6_empty_idle", 36'(tw_valid), 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
